// File: rtl/multi_port_scoreboard_if.sv
// multi_port_scoreboard_if: issue, writeback, lookup and commit bundle of the scoreboard.
// Suffixes are relative to the scoreboard; the slave modport is the scoreboard side.
interface multi_port_scoreboard_if #(
    parameter int NR_ENTRIES      = 8,
    parameter int NR_WB_PORTS     = 4,
    parameter int NR_COMMIT_PORTS = 2,
    parameter int NR_RD_PORTS     = 2,
    parameter int DATA_WIDTH      = 64,
    parameter int REG_ADDR_BITS   = 5
);
    localparam int TID_BITS = $clog2(NR_ENTRIES);
    logic                                             flush_i;
    logic                                             issue_valid_i;
    logic                                             issue_ready_o;
    logic [REG_ADDR_BITS-1:0]                         issue_rd_i;
    logic [TID_BITS-1:0]                              issue_trans_id_o;
    logic [NR_WB_PORTS-1:0]                           wb_valid_i;
    logic [NR_WB_PORTS-1:0][TID_BITS-1:0]             wb_trans_id_i;
    logic [NR_WB_PORTS-1:0][DATA_WIDTH-1:0]           wb_data_i;
    logic [NR_WB_PORTS-1:0]                           wb_ex_i;
    logic [NR_RD_PORTS-1:0][REG_ADDR_BITS-1:0]        rs_addr_i;
    logic [NR_RD_PORTS-1:0]                           rs_busy_o;
    logic [NR_RD_PORTS-1:0]                           rs_valid_o;
    logic [NR_RD_PORTS-1:0][DATA_WIDTH-1:0]           rs_data_o;
    logic [NR_COMMIT_PORTS-1:0]                       commit_valid_o;
    logic [NR_COMMIT_PORTS-1:0][REG_ADDR_BITS-1:0]    commit_rd_o;
    logic [NR_COMMIT_PORTS-1:0][DATA_WIDTH-1:0]       commit_data_o;
    logic [NR_COMMIT_PORTS-1:0]                       commit_ex_o;
    logic [NR_COMMIT_PORTS-1:0][TID_BITS-1:0]         commit_trans_id_o;
    logic [NR_COMMIT_PORTS-1:0]                       commit_ack_i;
    logic [TID_BITS:0]                                occupancy_o;

    modport master (
        output flush_i, issue_valid_i, issue_rd_i, wb_valid_i, wb_trans_id_i, wb_data_i, wb_ex_i,
               rs_addr_i, commit_ack_i,
        input  issue_ready_o, issue_trans_id_o, rs_busy_o, rs_valid_o, rs_data_o, commit_valid_o,
               commit_rd_o, commit_data_o, commit_ex_o, commit_trans_id_o, occupancy_o
    );

    modport slave (
        input  flush_i, issue_valid_i, issue_rd_i, wb_valid_i, wb_trans_id_i, wb_data_i, wb_ex_i,
               rs_addr_i, commit_ack_i,
        output issue_ready_o, issue_trans_id_o, rs_busy_o, rs_valid_o, rs_data_o, commit_valid_o,
               commit_rd_o, commit_data_o, commit_ex_o, commit_trans_id_o, occupancy_o
    );
endinterface

// File: rtl/multi_port_scoreboard.sv
// multi_port_scoreboard: in-order circular-buffer scoreboard with out-of-order writeback,
// forwarding operand lookups and in-order multi-port retirement.
module multi_port_scoreboard #(
    parameter int NR_ENTRIES      = 8,
    parameter int NR_WB_PORTS     = 4,
    parameter int NR_COMMIT_PORTS = 2,
    parameter int NR_RD_PORTS     = 2,
    parameter int DATA_WIDTH      = 64,
    parameter int REG_ADDR_BITS   = 5
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    multi_port_scoreboard_if.slave sb
);
    localparam int TID_BITS = $clog2(NR_ENTRIES);
    localparam int CNT_BITS = TID_BITS + 1;
    typedef logic [TID_BITS-1:0] tid_t;

    logic [NR_ENTRIES-1:0]                     valid_q, valid_d, done_q, done_d, ex_q, ex_d;
    logic [NR_ENTRIES-1:0][REG_ADDR_BITS-1:0]  rd_q, rd_d;
    logic [NR_ENTRIES-1:0][DATA_WIDTH-1:0]     data_q, data_d;
    tid_t                                      head_q, head_d, tail_q, tail_d;
    logic [CNT_BITS-1:0]                       cnt_q, cnt_d, n_ret;
    logic                                      issue_fire;
    logic [NR_COMMIT_PORTS-1:0]                cv, ret;
    logic [NR_ENTRIES-1:0]                     retiring;

    assign sb.issue_ready_o    = cnt_q < CNT_BITS'(NR_ENTRIES);
    assign sb.issue_trans_id_o = tail_q;
    assign sb.occupancy_o      = cnt_q;
    assign issue_fire          = sb.issue_valid_i & sb.issue_ready_o;

    always_comb begin
        logic run_v, run_r;
        tid_t e;
        cv       = '0;
        ret      = '0;
        retiring = '0;
        n_ret    = '0;
        run_v    = 1'b1;
        run_r    = 1'b1;
        e        = head_q;
        sb.commit_valid_o    = '0;
        sb.commit_rd_o       = '0;
        sb.commit_data_o     = '0;
        sb.commit_ex_o       = '0;
        sb.commit_trans_id_o = '0;
        for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
            e       = head_q + tid_t'(k);
            cv[k]   = run_v & valid_q[e] & done_q[e];
            run_v   = cv[k];
            ret[k]  = run_r & cv[k] & sb.commit_ack_i[k];
            run_r   = ret[k];
            retiring[e] = ret[k];
            n_ret   = n_ret + CNT_BITS'(ret[k]);
            sb.commit_valid_o[k]    = cv[k];
            sb.commit_rd_o[k]       = cv[k] ? rd_q[e] : '0;
            sb.commit_data_o[k]     = cv[k] ? data_q[e] : '0;
            sb.commit_ex_o[k]       = cv[k] & ex_q[e];
            sb.commit_trans_id_o[k] = cv[k] ? e : '0;
        end
    end

    // Later ports overwrite earlier ones, so the highest port index wins on an ID clash.
    always_comb begin
        tid_t id;
        valid_d = valid_q & ~retiring;
        done_d  = done_q & ~retiring;
        ex_d    = ex_q;
        rd_d    = rd_q;
        data_d  = data_q;
        id      = '0;
        for (int p = 0; p < NR_WB_PORTS; p++) begin
            id = sb.wb_trans_id_i[p];
            if (sb.wb_valid_i[p] && valid_q[id] && !retiring[id]) begin
                done_d[id] = 1'b1;
                data_d[id] = sb.wb_data_i[p];
                ex_d[id]   = sb.wb_ex_i[p];
            end
        end
        if (issue_fire) begin
            valid_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
            ex_d[tail_q]    = 1'b0;
            rd_d[tail_q]    = sb.issue_rd_i;
        end
        head_d = head_q + tid_t'(n_ret);
        tail_d = tail_q + tid_t'(issue_fire);
        cnt_d  = cnt_q + CNT_BITS'(issue_fire) - n_ret;
    end

    // Valid entries are contiguous from head, so the last match in the scan is the youngest.
    always_comb begin
        logic hit;
        tid_t e, sel;
        sb.rs_busy_o  = '0;
        sb.rs_valid_o = '0;
        sb.rs_data_o  = '0;
        hit = 1'b0;
        e   = '0;
        sel = '0;
        for (int r = 0; r < NR_RD_PORTS; r++) begin
            hit = 1'b0;
            sel = '0;
            for (int i = 0; i < NR_ENTRIES; i++) begin
                e = head_q + tid_t'(i);
                if (valid_q[e] && rd_q[e] == sb.rs_addr_i[r]) begin
                    hit = 1'b1;
                    sel = e;
                end
            end
            hit = hit & (sb.rs_addr_i[r] != '0);
            sb.rs_busy_o[r] = hit;
            if (hit && done_q[sel]) begin
                sb.rs_valid_o[r] = 1'b1;
                sb.rs_data_o[r]  = data_q[sel];
            end
            for (int p = 0; p < NR_WB_PORTS; p++) begin
                if (hit && !done_q[sel] && sb.wb_valid_i[p] && sb.wb_trans_id_i[p] == sel) begin
                    sb.rs_valid_o[r] = 1'b1;
                    sb.rs_data_o[r]  = sb.wb_data_i[p];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            done_q  <= '0;
            ex_q    <= '0;
            rd_q    <= '0;
            data_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
        end else if (sb.flush_i) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            ex_q    <= ex_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_multi_port_scoreboard.sv
// tb_multi_port_scoreboard: directed vectors with hand-computed expectations for the
// default 8-entry, 4-wb, 2-commit, 2-read configuration.
module tb_multi_port_scoreboard;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    multi_port_scoreboard_if sbif ();
    multi_port_scoreboard dut (.clk_i(clk), .rst_ni(rst_n), .sb(sbif));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sbif.flush_i       = 1'b0;
        sbif.issue_valid_i = 1'b0;
        sbif.issue_rd_i    = '0;
        sbif.wb_valid_i    = '0;
        sbif.wb_trans_id_i = '0;
        sbif.wb_data_i     = '0;
        sbif.wb_ex_i       = '0;
        sbif.rs_addr_i     = '0;
        sbif.commit_ack_i  = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wb(input int p, input logic [2:0] id, input logic [63:0] d, input logic ex);
        sbif.wb_valid_i[p]    = 1'b1;
        sbif.wb_trans_id_i[p] = id;
        sbif.wb_data_i[p]     = d;
        sbif.wb_ex_i[p]       = ex;
    endtask

    initial begin
        // reset state and fill to full
        do_reset();
        sbif.rs_addr_i[0] = 5'd1;
        #1;
        chk("rst_ready", sbif.issue_ready_o, 1);
        chk("rst_occ", sbif.occupancy_o, 0);
        chk("rst_cv", sbif.commit_valid_o, 0);
        chk("rst_busy", sbif.rs_busy_o, 0);
        chk("rst_cdata", sbif.commit_data_o[0], 0);
        for (int i = 0; i < 8; i++) begin
            sbif.issue_valid_i = 1'b1;
            sbif.issue_rd_i    = 5'(i + 1);
            #1;
            chk("fill_tid", sbif.issue_trans_id_o, i);
            chk("fill_ready", sbif.issue_ready_o, 1);
            tick();
        end
        idle();
        #1;
        chk("full_ready", sbif.issue_ready_o, 0);
        chk("full_occ", sbif.occupancy_o, 8);
        chk("full_cv", sbif.commit_valid_o, 0);
        sbif.issue_valid_i = 1'b1;
        sbif.issue_rd_i    = 5'd9;
        tick();
        idle();
        sbif.rs_addr_i[0] = 5'd3;
        sbif.rs_addr_i[1] = 5'd9;
        #1;
        chk("refused_occ", sbif.occupancy_o, 8);
        chk("full_busy", sbif.rs_busy_o, 2'b01);
        chk("full_rsvalid", sbif.rs_valid_o, 2'b00);
        wb(0, 3'd0, 64'h11, 1'b0);
        tick();
        idle();
        sbif.issue_valid_i = 1'b1;
        sbif.issue_rd_i    = 5'd20;
        sbif.commit_ack_i  = 2'b01;
        #1;
        chk("full_cmt_cv", sbif.commit_valid_o, 2'b01);
        chk("full_cmt_ready", sbif.issue_ready_o, 0);
        tick();
        idle();
        #1;
        chk("full_cmt_occ", sbif.occupancy_o, 7);
        chk("full_cmt_ready2", sbif.issue_ready_o, 1);
        chk("full_cmt_tid", sbif.issue_trans_id_o, 0);

        // forwarding of a writeback, then stored value
        do_reset();
        sbif.issue_valid_i = 1'b1;
        sbif.issue_rd_i    = 5'd5;
        sbif.rs_addr_i[0]  = 5'd5;
        #1;
        chk("fwd_tid", sbif.issue_trans_id_o, 0);
        chk("fwd_issue_invis", sbif.rs_busy_o, 0);
        tick();
        sbif.issue_valid_i = 1'b0;
        wb(1, 3'd0, 64'hCD, 1'b0);
        wb(3, 3'd0, 64'hAB, 1'b1);
        #1;
        chk("fwd_busy", sbif.rs_busy_o, 2'b01);
        chk("fwd_valid", sbif.rs_valid_o, 2'b01);
        chk("fwd_data", sbif.rs_data_o[0], 64'hAB);
        chk("fwd_no_bypass", sbif.commit_valid_o, 0);
        tick();
        sbif.wb_valid_i = '0;
        #1;
        chk("st_busy", sbif.rs_busy_o, 2'b01);
        chk("st_valid", sbif.rs_valid_o, 2'b01);
        chk("st_data", sbif.rs_data_o[0], 64'hAB);
        chk("st_cv", sbif.commit_valid_o, 2'b01);
        chk("st_crd", sbif.commit_rd_o[0], 5);
        chk("st_cdata", sbif.commit_data_o[0], 64'hAB);
        chk("st_cex", sbif.commit_ex_o, 2'b01);

        // out-of-order writeback, in-order commit
        do_reset();
        for (int i = 0; i < 3; i++) begin
            sbif.issue_valid_i = 1'b1;
            sbif.issue_rd_i    = 5'(10 + i);
            tick();
        end
        idle();
        wb(0, 3'd2, 64'h22, 1'b0);
        tick();
        idle();
        wb(2, 3'd1, 64'h21, 1'b0);
        tick();
        idle();
        #1;
        chk("ooo_cv0", sbif.commit_valid_o, 2'b00);
        wb(1, 3'd0, 64'h20, 1'b0);
        #1;
        chk("ooo_cv_nobyp", sbif.commit_valid_o, 2'b00);
        tick();
        idle();
        #1;
        chk("ooo_cv", sbif.commit_valid_o, 2'b11);
        chk("ooo_tid", sbif.commit_trans_id_o, 6'b001_000);
        chk("ooo_rd1", sbif.commit_rd_o[1], 11);
        chk("ooo_data0", sbif.commit_data_o[0], 64'h20);
        sbif.commit_ack_i = 2'b10;
        tick();
        #1;
        chk("ack10_cv", sbif.commit_valid_o, 2'b11);
        chk("ack10_occ", sbif.occupancy_o, 3);
        chk("ack10_tid", sbif.commit_trans_id_o[0], 0);
        sbif.commit_ack_i = 2'b11;
        tick();
        sbif.commit_ack_i = 2'b00;
        #1;
        chk("ack11_cv", sbif.commit_valid_o, 2'b01);
        chk("ack11_tid", sbif.commit_trans_id_o[0], 2);
        chk("ack11_occ", sbif.occupancy_o, 1);

        // youngest writer wins
        do_reset();
        for (int i = 0; i < 2; i++) begin
            sbif.issue_valid_i = 1'b1;
            sbif.issue_rd_i    = 5'd3;
            tick();
        end
        idle();
        wb(0, 3'd0, 64'h55, 1'b0);
        tick();
        idle();
        sbif.rs_addr_i[0] = 5'd3;
        #1;
        chk("yw_busy", sbif.rs_busy_o, 2'b01);
        chk("yw_valid", sbif.rs_valid_o, 2'b00);
        chk("yw_data", sbif.rs_data_o[0], 0);
        wb(2, 3'd1, 64'h77, 1'b0);
        #1;
        chk("yw_fwd_valid", sbif.rs_valid_o, 2'b01);
        chk("yw_fwd_data", sbif.rs_data_o[0], 64'h77);

        // wrap-around, then flush
        do_reset();
        for (int i = 0; i < 20; i++) begin
            idle();
            sbif.issue_valid_i = 1'b1;
            sbif.issue_rd_i    = 5'd7;
            #1;
            chk("wrap_tid", sbif.issue_trans_id_o, i % 8);
            tick();
            idle();
            wb(0, 3'(i % 8), 64'(i), 1'b0);
            tick();
            idle();
            sbif.commit_ack_i = 2'b01;
            #1;
            if (i % 5 == 0) chk("wrap_ctid", sbif.commit_trans_id_o[0], i % 8);
            tick();
        end
        idle();
        #1;
        chk("wrap_occ", sbif.occupancy_o, 0);
        for (int i = 0; i < 4; i++) begin
            sbif.issue_valid_i = 1'b1;
            sbif.issue_rd_i    = 5'(i + 1);
            tick();
        end
        idle();
        sbif.flush_i       = 1'b1;
        sbif.issue_valid_i = 1'b1;
        sbif.issue_rd_i    = 5'd9;
        wb(0, 3'd4, 64'h99, 1'b0);
        tick();
        idle();
        sbif.rs_addr_i[0] = 5'd2;
        #1;
        chk("fl_occ", sbif.occupancy_o, 0);
        chk("fl_ready", sbif.issue_ready_o, 1);
        chk("fl_cv", sbif.commit_valid_o, 0);
        chk("fl_tid", sbif.issue_trans_id_o, 0);
        chk("fl_busy", sbif.rs_busy_o, 0);
        wb(3, 3'd0, 64'hEE, 1'b0);
        tick();
        idle();
        sbif.issue_valid_i = 1'b1;
        sbif.issue_rd_i    = 5'd9;
        tick();
        idle();
        sbif.rs_addr_i[0] = 5'd9;
        #1;
        chk("late_wb_cv", sbif.commit_valid_o, 0);
        chk("late_wb_busy", sbif.rs_busy_o, 2'b01);
        chk("late_wb_valid", sbif.rs_valid_o, 0);
        chk("late_wb_occ", sbif.occupancy_o, 1);
        chk("x0_busy", sbif.rs_busy_o[1], 0);
        chk("x0_valid", sbif.rs_valid_o[1], 0);
        chk("x0_data", sbif.rs_data_o[1], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/multi_port_scoreboard.md
Name: multi_port_scoreboard

Overview:
Parametrised in-order scoreboard for the issue stage. It tracks in-flight instructions in a circular buffer and allocates transaction IDs at issue. It accepts out-of-order writeback on NR_WB_PORTS ports, serves NR_RD_PORTS operand lookups with same-cycle writeback forwarding, and retires in order over NR_COMMIT_PORTS ports. Compared with the current fixed rs1/rs2 scoreboard, it adds a generalised read-port count, a data width parameter, occupancy reporting and defined multi-port conflict rules.

Parameters:
NR_ENTRIES, 8, buffer depth; power of two, at least 2; ID width TID_BITS = log2(NR_ENTRIES)
NR_WB_PORTS, 4, writeback ports
NR_COMMIT_PORTS, 2, commit ports; at most NR_ENTRIES
NR_RD_PORTS, 2, operand lookup ports
DATA_WIDTH, 64, result width
REG_ADDR_BITS, 5, architectural register address width

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous, active-low
flush_i  in  1  discard all entries
issue_valid_i  in  1  new instruction offered
issue_ready_o  out  1  free slot available
issue_rd_i  in  REG_ADDR_BITS  destination register
issue_trans_id_o  out  TID_BITS  ID assigned to the offered instruction (tail index)
wb_valid_i  in  NR_WB_PORTS  writeback strobes
wb_trans_id_i  in  NR_WB_PORTS*TID_BITS  writeback IDs
wb_data_i  in  NR_WB_PORTS*DATA_WIDTH  writeback data
wb_ex_i  in  NR_WB_PORTS  writeback carries an exception
rs_addr_i  in  NR_RD_PORTS*REG_ADDR_BITS  lookup addresses
rs_busy_o  out  NR_RD_PORTS  an in-flight entry will write this register
rs_valid_o  out  NR_RD_PORTS  forwarded value available
rs_data_o  out  NR_RD_PORTS*DATA_WIDTH  forwarded value
commit_valid_o  out  NR_COMMIT_PORTS  port k holds a retirable entry
commit_rd_o  out  NR_COMMIT_PORTS*REG_ADDR_BITS
commit_data_o  out  NR_COMMIT_PORTS*DATA_WIDTH
commit_ex_o  out  NR_COMMIT_PORTS
commit_trans_id_o  out  NR_COMMIT_PORTS*TID_BITS
commit_ack_i  in  NR_COMMIT_PORTS  retire acknowledge
occupancy_o  out  TID_BITS+1  valid entry count

Behaviour:
- State:
  - per-entry valid, done, ex, rd, data;
  - head, tail (TID_BITS, wrap modulo NR_ENTRIES);
  - count (TID_BITS+1).
- Reset (async) and flush (sync, next edge):
  - all valid/done cleared; head = tail = count = 0.
  - After reset: issue_ready_o = 1; all commit_* and rs_* outputs = 0; occupancy_o = 0.
- Issue:
  - issue_ready_o = (count < NR_ENTRIES), from registered count only. A commit in the same cycle does not free a slot until the next cycle.
  - On valid && ready: entry[tail] gets valid = 1, done = 0, ex = 0, rd; tail increments; issue_trans_id_o = tail.
  - rd = 0 still occupies an entry.
- Writeback:
  - Port p sets done, data and ex of entry[wb_trans_id_i[p]] when that entry is valid. Writeback to an invalid entry is ignored.
  - Same ID on several ports in one cycle: highest port index wins.
  - Writeback to an entry retiring in the same cycle is ignored.
- Commit:
  - commit_valid_o[k] = 1 only if entry[head+k] is valid and done, and commit_valid_o[k-1] = 1 (in-order prefix).
  - Outputs are combinational from registers; no same-cycle writeback bypass.
  - Retired count n = length of the leading run where commit_ack_i[k] && commit_valid_o[k]. Acks outside that prefix are ignored.
  - Retiring clears valid for entries head..head+n-1; head += n.
- Count update: count_next = count + issued - n. occupancy_o = count.
- Operand lookup (combinational), per read port r:
  - Address 0: busy = valid = 0, data = 0.
  - Otherwise select the youngest valid entry with a matching rd (closest to tail, scanning across the wrap). busy = 1 if one exists.
  - If that entry is done: valid = 1, data = entry data.
  - Else if any wb port writes that entry's ID this cycle: valid = 1, data = that port's data (highest index wins).
  - Else valid = 0 and data = 0.
  - The instruction being issued in the same cycle is not visible to lookups.
- Flush priority:
  - Issue, writeback and commit in the flush cycle have no effect on state.
  - Commit outputs in the flush cycle still reflect the pre-flush registers; the consumer must not act on them.
- Full/empty:
  - count = NR_ENTRIES with head == tail means full; count = 0 means empty.
  - Simultaneous issue and commit at full: commit proceeds, issue is refused.

Test Plan:
- Reset, then issue 8 instructions with rd = 1..8 and no writeback → trans_ids 0..7; issue_ready_o drops to 0 after the 8th; occupancy_o = 8; commit_valid_o = 00.
- Issue rd = 5 (ID 0); same cycle wb port 3 writes ID 0 with data 0xAB; lookup of x5 → busy = 1, valid = 1, data = 0xAB. Next cycle, still uncommitted → same values from the stored entry.
- Issue IDs 0,1,2; writeback 2 then 1 → commit_valid_o = 00. Writeback 0 → commit_valid_o = 11 with IDs 0,1. Ack = 11 → the next cycle shows ID 2 on port 0.
- Ack = 10 with both commit ports valid → nothing retires; head unchanged.
- Issue two writers of x3 (IDs 0,1); only ID 0 done → lookup of x3 gives busy = 1, valid = 0 (youngest writer wins).
- Wrap-around: run 20 issue/commit pairs and check IDs cycle 0..7. Then flush with 4 entries live → occupancy_o = 0 next cycle, issue_ready_o = 1, a late writeback to an old ID is ignored. Lookups of x0 always return busy = 0, valid = 0, data = 0.
